// File: rtl/weight_addr_seq_if.sv
// weight_addr_seq address stream interface
// valid/ready weight address bus with window/filter markers
interface weight_addr_seq_if #(
  parameter int ADDR_W = 10
);
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] weight_addr;
  logic              win_last;
  logic              filt_last;

  modport master (
    output addr_valid,
    output weight_addr,
    output win_last,
    output filt_last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid,
    input  weight_addr,
    input  win_last,
    input  filt_last,
    output addr_ready
  );
endinterface

// File: rtl/weight_addr_seq.sv
// weight_addr_seq: conv weight address generator
// filter/window/channel/tap walk, weight-set replay per window
module weight_addr_seq #(
  parameter int ADDR_W = 10,
  parameter int KSIZE  = 3,
  parameter int CH_W   = 8,
  parameter int PIX_W  = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CH_W-1:0]   cfg_cin,
  input  logic [CH_W-1:0]   cfg_cout,
  input  logic [PIX_W-1:0]  cfg_pix,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  weight_addr_seq_if.master aif
);

  localparam int K2    = KSIZE * KSIZE;
  localparam int TAP_W = (K2 > 1) ? $clog2(K2) : 1;
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(K2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CH_W-1:0]   r_cin;
  logic [CH_W-1:0]   r_cout;
  logic [PIX_W-1:0]  r_pix;
  logic [ADDR_W-1:0] r_fbase;
  logic [ADDR_W-1:0] r_addr;
  logic [TAP_W-1:0]  r_tap;
  logic [CH_W-1:0]   r_ch;
  logic [PIX_W-1:0]  r_win;
  logic [CH_W-1:0]   r_filt;

  logic w_run;
  logic w_hs;
  logic w_cfg_zero;
  logic w_tap_end;
  logic w_ch_end;
  logic w_win_end;
  logic w_filt_end;
  logic w_win_last;
  logic w_filt_last;

  assign w_run      = (r_state == S_RUN);
  assign w_hs       = w_run & aif.addr_ready;
  assign w_cfg_zero = (cfg_cin == '0) | (cfg_cout == '0)
                    | (cfg_pix == '0);
  assign w_tap_end  = (r_tap == TAP_LAST);
  assign w_ch_end   = (r_ch == r_cin - CH_W'(1));
  assign w_win_end  = (r_win == r_pix - PIX_W'(1));
  assign w_filt_end = (r_filt == r_cout - CH_W'(1));
  assign w_win_last  = w_run & w_tap_end & w_ch_end;
  assign w_filt_last = w_win_last & w_win_end;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next state: abort wins over a coincident final handshake
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_cfg_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (abort)
          w_next = S_DONE;
        else if (w_hs & w_filt_last & w_filt_end)
          w_next = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs decoded from state and counters
  always_comb begin
    busy            = w_run;
    done            = (r_state == S_DONE);
    aif.addr_valid  = w_run;
    aif.weight_addr = r_addr;
    aif.win_last    = w_win_last;
    aif.filt_last   = w_filt_last;
  end

  // config capture and tap/channel/window/filter walk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cin   <= '0;
      r_cout  <= '0;
      r_pix   <= '0;
      r_fbase <= '0;
      r_addr  <= '0;
      r_tap   <= '0;
      r_ch    <= '0;
      r_win   <= '0;
      r_filt  <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_cin   <= cfg_cin;
      r_cout  <= cfg_cout;
      r_pix   <= cfg_pix;
      r_fbase <= cfg_base;
      r_addr  <= cfg_base;
      r_tap   <= '0;
      r_ch    <= '0;
      r_win   <= '0;
      r_filt  <= '0;
    end else if (w_hs) begin
      if (!w_tap_end) begin
        r_tap  <= r_tap + TAP_W'(1);
        r_addr <= r_addr + ADDR_W'(1);
      end else begin
        r_tap <= '0;
        if (!w_ch_end) begin
          r_ch   <= r_ch + CH_W'(1);
          r_addr <= r_addr + ADDR_W'(1);
        end else begin
          r_ch <= '0;
          if (!w_win_end) begin
            r_win  <= r_win + PIX_W'(1);
            r_addr <= r_fbase;
          end else begin
            r_win   <= '0;
            r_filt  <= r_filt + CH_W'(1);
            r_fbase <= r_addr + ADDR_W'(1);
            r_addr  <= r_addr + ADDR_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_addr_seq.sv
// tb_weight_addr_seq: directed checks for weight_addr_seq
// two instances: ADDR_W=10 main, ADDR_W=4 for wrap
module tb_weight_addr_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic go, sel4, rdy, abort;
  logic start, start4;
  logic [9:0]  base10;
  logic [3:0]  base4;
  logic [7:0]  cin, cout;
  logic [11:0] pix;
  logic busy, done, busy4, done4;

  weight_addr_seq_if #(.ADDR_W(10)) bus ();
  weight_addr_seq_if #(.ADDR_W(4))  bus4 ();

  assign start  = go & ~sel4;
  assign start4 = go & sel4;
  assign bus.addr_ready  = rdy;
  assign bus4.addr_ready = rdy;

  weight_addr_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_base(base10), .cfg_cin(cin), .cfg_cout(cout),
    .cfg_pix(pix), .abort(abort), .busy(busy),
    .done(done), .aif(bus)
  );

  weight_addr_seq #(.ADDR_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .cfg_base(base4), .cfg_cin(cin), .cfg_cout(cout),
    .cfg_pix(pix), .abort(abort), .busy(busy4),
    .done(done4), .aif(bus4)
  );

  logic o_valid, o_wl, o_fl, o_busy, o_done;
  logic [31:0] o_addr;

  always_comb begin
    o_valid = sel4 ? bus4.addr_valid : bus.addr_valid;
    o_wl    = sel4 ? bus4.win_last   : bus.win_last;
    o_fl    = sel4 ? bus4.filt_last  : bus.filt_last;
    o_busy  = sel4 ? busy4 : busy;
    o_done  = sel4 ? done4 : done;
    o_addr  = sel4 ? 32'(bus4.weight_addr)
                   : 32'(bus.weight_addr);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  int obs_q[$];
  int fl_q[$];
  int hs_n;

  task automatic run_job(input string tag, input int base,
                         input int nci, input int nco,
                         input int npx, input int aw,
                         input bit rnd);
    int ea[$];
    bit ew[$];
    bit ef[$];
    int idx, cyc, last_hs, s_addr;
    bit fin, stall, s_wl, s_fl;
    obs_q.delete();
    fl_q.delete();
    for (int f = 0; f < nco; f++)
      for (int p = 0; p < npx; p++)
        for (int c = 0; c < nci; c++)
          for (int k = 0; k < 9; k++) begin
            ea.push_back((base + f*nci*9 + c*9 + k) % (1 << aw));
            ew.push_back(k == 8 && c == nci-1);
            ef.push_back(k == 8 && c == nci-1 && p == npx-1);
          end
    @(negedge clk);
    sel4   = (aw == 4);
    base10 = 10'(base);
    base4  = 4'(base);
    cin    = 8'(nci);
    cout   = 8'(nco);
    pix    = 12'(npx);
    go     = 1'b1;
    @(negedge clk);
    cin = 8'd5; cout = 8'd7; pix = 12'd3;
    base10 = 10'd999; base4 = 4'd9;
    idx = 0; cyc = 0; last_hs = -10;
    fin = 0; stall = 0;
    s_addr = 0; s_wl = 0; s_fl = 0;
    while (!fin && cyc < 3000) begin
      if (stall)
        check({tag, " hold"}, {o_wl, o_fl, o_addr[29:0]},
              {s_wl, s_fl, 30'(s_addr)});
      if (o_done) begin
        fin = 1;
        check({tag, " done_lat"}, cyc, last_hs + 1);
        check({tag, " count"}, idx, ea.size());
        go = 1'b0;
      end else begin
        check({tag, " run"}, {o_valid, o_busy}, 2'b11);
        rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        stall = o_valid & ~rdy;
        if (o_valid & rdy) begin
          if (idx < ea.size())
            check({tag, " addr"}, {o_wl, o_fl, o_addr[29:0]},
                  {ew[idx], ef[idx], 30'(ea[idx])});
          else
            check({tag, " extra"}, 1, 0);
          obs_q.push_back(int'(o_addr));
          if (o_fl) fl_q.push_back(int'(o_addr));
          idx++;
          last_hs = cyc;
        end else if (stall) begin
          s_addr = int'(o_addr);
          s_wl = o_wl;
          s_fl = o_fl;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check({tag, " timeout"}, 0, 1);
    go = 1'b0;
    hs_n = idx;
    rdy = 1'b1;
    @(negedge clk);
    check({tag, " idle"}, {o_valid, o_busy, o_done}, 0);
  endtask

  initial begin
    reset = 1'b1;
    go = 0; sel4 = 0; rdy = 1; abort = 0;
    base10 = 0; base4 = 0; cin = 0; cout = 0; pix = 0;
    repeat (2) @(negedge clk);
    check("rst out", {o_valid, o_busy, o_done, o_wl, o_fl},
          0);
    check("rst addr", o_addr, 0);
    reset = 1'b0;

    run_job("basic", 0, 1, 1, 1, 10, 0);
    check("basic n", hs_n, 9);
    if (obs_q.size() == 9) check("basic a8", obs_q[8], 8);
    else check("basic size", obs_q.size(), 9);
    if (fl_q.size() == 1) check("basic fl", fl_q[0], 8);
    else check("basic flsz", fl_q.size(), 1);

    run_job("rep", 100, 2, 2, 2, 10, 0);
    check("rep n", hs_n, 72);
    if (obs_q.size() == 72) begin
      check("rep a17", obs_q[17], 117);
      check("rep a18", obs_q[18], 100);
      check("rep a36", obs_q[36], 118);
      check("rep a71", obs_q[71], 135);
    end else check("rep size", obs_q.size(), 72);
    if (fl_q.size() == 2) begin
      check("rep fl0", fl_q[0], 117);
      check("rep fl1", fl_q[1], 135);
    end else check("rep flsz", fl_q.size(), 2);

    run_job("bp", 100, 2, 2, 2, 10, 1);
    check("bp n", hs_n, 72);

    run_job("wrap", 14, 1, 1, 1, 4, 0);
    if (obs_q.size() == 9) begin
      check("wrap a0", obs_q[0], 14);
      check("wrap a1", obs_q[1], 15);
      check("wrap a2", obs_q[2], 0);
      check("wrap a8", obs_q[8], 6);
    end else check("wrap size", obs_q.size(), 9);
    sel4 = 0;

    // abort on the 5th address during a stall
    base10 = 0; cin = 1; cout = 1; pix = 1; rdy = 1;
    go = 1;
    @(negedge clk);
    go = 0;
    repeat (4) @(negedge clk);
    rdy = 0; abort = 1;
    check("ab addr", o_addr, 4);
    @(negedge clk);
    abort = 0;
    check("ab done", {o_valid, o_done}, 2'b01);
    @(negedge clk);
    rdy = 1;
    check("ab idle", {o_valid, o_busy, o_done}, 0);

    // abort together with the final handshake
    go = 1;
    @(negedge clk);
    go = 0;
    repeat (8) @(negedge clk);
    abort = 1;
    check("abf last", {o_wl, o_fl, o_addr[29:0]},
          {2'b11, 30'd8});
    @(negedge clk);
    abort = 0;
    check("abf done", {o_valid, o_done}, 2'b01);
    @(negedge clk);
    check("abf once", {o_valid, o_busy, o_done}, 0);

    // abort in idle is ignored
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("ab idle2", {o_valid, o_busy, o_done}, 0);

    // reset mid-job, then start on the first edge after
    base10 = 50; cin = 2; cout = 1; pix = 1;
    go = 1;
    @(negedge clk);
    go = 0;
    repeat (3) @(negedge clk);
    #2 reset = 1;
    #1 check("rst mid", {o_valid, o_busy, o_done,
                         o_addr[28:0]}, 0);
    @(negedge clk);
    check("rst hold", {o_done, o_busy}, 0);
    reset = 0;
    base10 = 20; cin = 1;
    go = 1;
    @(negedge clk);
    go = 0;
    check("rst restart", {o_valid, o_done, o_addr[29:0]},
          {2'b10, 30'd20});
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("rst ab done", {o_valid, o_done}, 2'b01);
    @(negedge clk);

    // zero-sized job: straight to done, never valid
    for (int i = 0; i < 3; i++) begin
      cin  = (i == 0) ? 8'd0 : 8'd1;
      cout = (i == 1) ? 8'd0 : 8'd1;
      pix  = (i == 2) ? 12'd0 : 12'd1;
      go = 1;
      @(negedge clk);
      go = 0;
      check("zero done", {o_valid, o_busy, o_done}, 3'b001);
      @(negedge clk);
      check("zero idle", {o_valid, o_busy, o_done}, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
